// File: rtl/prime_sched.sv
// Round-robin scheduler sharing one prime-step sequence (0,2,3,5,7) between two
// requesters; each granted burst streams 1-8 values, then pulses that requester's done.
module prime_sched (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic       req1,
  input  logic [2:0] len0,
  input  logic [2:0] len1,
  input  logic       seq_clr,
  output logic       grant0,
  output logic       grant1,
  output logic [2:0] prime,
  output logic       prime_valid,
  output logic       done0,
  output logic       done1
);

  localparam int unsigned VW = 3;
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {IDLE, SERVE, DONE} state_t;

  state_t         state;
  logic [VW-1:0]  seq;        // next value to be emitted
  logic [CW-1:0]  remaining;
  logic           owner;
  logic           rr_last;

  logic           any_req_c;
  logic           last_c;
  logic           winner_c;
  logic [VW-1:0]  win_len_c;
  logic [CW-1:0]  burst_len_c;
  logic [VW-1:0]  start_seq_c;

  function automatic logic [VW-1:0] seq_next(input logic [VW-1:0] v);
    case (v)
      VW'(7):  seq_next = '0;
      VW'(2):  seq_next = VW'(3);
      default: seq_next = v + VW'(2);
    endcase
  endfunction

  // Arbitration also runs in DONE, where the finishing owner counts as last served.
  always_comb begin
    any_req_c   = req0 | req1;
    last_c      = (state == DONE) ? owner : rr_last;
    winner_c    = (req0 & req1) ? ~last_c : req1;
    win_len_c   = winner_c ? len1 : len0;
    burst_len_c = (win_len_c == '0) ? CW'(8) : {1'b0, win_len_c};
    start_seq_c = ((state == IDLE) && seq_clr) ? '0 : seq;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      seq         <= '0;
      remaining   <= '0;
      owner       <= 1'b0;
      rr_last     <= 1'b1;
      grant0      <= 1'b0;
      grant1      <= 1'b0;
      prime       <= '0;
      prime_valid <= 1'b0;
      done0       <= 1'b0;
      done1       <= 1'b0;
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (state == DONE) rr_last <= owner;
          grant0      <= 1'b0;
          grant1      <= 1'b0;
          prime_valid <= 1'b0;
          prime       <= '0;
          if ((state == IDLE) && seq_clr) seq <= '0;
          if (any_req_c) begin
            owner       <= winner_c;
            remaining   <= burst_len_c;
            grant0      <= ~winner_c;
            grant1      <= winner_c;
            prime_valid <= 1'b1;
            prime       <= start_seq_c;
            seq         <= seq_next(start_seq_c);
            state       <= SERVE;
          end else begin
            state <= IDLE;
          end
        end
        SERVE: begin
          if (remaining == CW'(1)) begin
            grant0      <= 1'b0;
            grant1      <= 1'b0;
            prime_valid <= 1'b0;
            prime       <= '0;
            done0       <= ~owner;
            done1       <= owner;
            state       <= DONE;
          end else begin
            remaining <= remaining - CW'(1);
            prime     <= seq;
            seq       <= seq_next(seq);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
